// File: rtl/tia_htiming_param.sv
// Horizontal timing for the TIA successor: binary line counter, blank/sync/burst decode,
// WSYNC stall, VSYNC/VBLANK latches. Define TIA_HTIMING_HMOVE_CLK_EN for the HMOVE motion pulse.
module tia_htiming_param #(
    parameter int LINE_CLKS   = 228,
    parameter int HBLANK_END  = 68,
    parameter int HMOVE_EXT   = 8,
    parameter int HSYNC_START = 20,
    parameter int HSYNC_END   = 36,
    parameter int CB_START    = 40,
    parameter int CB_END      = 56,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wsyn,
    input  logic             hmove,
    input  logic             rsync,
    input  logic             vsyn,
    input  logic             vblk,
    input  logic             d1,
    output logic [CNT_W-1:0] hcount,
    output logic             line_start,
    output logic             hblank,
    output logic             sec,
    output logic             vs,
    output logic             vb,
    output logic             vb_bar,
    output logic             blank,
    output logic             syn,
    output logic             cb,
    output logic             rdy,
    output logic             motck,
    output logic             hmc_pulse
);

    if ((64'd1 << CNT_W) < 64'(LINE_CLKS)) begin : g_cnt_w_check
        $error("CNT_W too narrow for LINE_CLKS");
    end

    logic             stall, hs, cb_win;
    logic             wrap, restart, sec_next, stall_next, hblank_next;
    logic [CNT_W-1:0] hcount_next;

    always_comb begin
        wrap        = (hcount == CNT_W'(LINE_CLKS - 1));
        restart     = wrap | rsync;
        hcount_next = restart ? '0 : hcount + 1'b1;
        sec_next    = hmove | (sec & ~restart);
        stall_next  = wsyn | (stall & ~restart);
        // The extension only prolongs a blank still in progress; once visible, stay visible.
        hblank_next = (hcount_next < CNT_W'(HBLANK_END)) |
                      (hblank & sec_next & (hcount_next < CNT_W'(HBLANK_END + HMOVE_EXT)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount     <= '0;
            line_start <= 1'b1;
            hblank     <= 1'b1;
            hs         <= 1'b0;
            cb_win     <= 1'b0;
            sec        <= 1'b0;
            stall      <= 1'b0;
            vs         <= 1'b0;
            vb         <= 1'b0;
        end else begin
            hcount     <= hcount_next;
            line_start <= (hcount_next == '0);
            hblank     <= hblank_next;
            hs         <= (hcount_next >= CNT_W'(HSYNC_START)) && (hcount_next < CNT_W'(HSYNC_END));
            cb_win     <= (hcount_next >= CNT_W'(CB_START)) && (hcount_next < CNT_W'(CB_END));
            sec        <= sec_next;
            stall      <= stall_next;
            if (vsyn) vs <= d1;
            if (vblk) vb <= d1;
        end
    end

    assign vb_bar = ~vb;
    assign blank  = hblank | vb;
    assign syn    = ~(vs ^ hs);
    assign cb     = ~vs & cb_win;
    assign rdy    = ~stall;
    assign motck  = ~hblank;

`ifdef TIA_HTIMING_HMOVE_CLK_EN
    logic [3:0] hmc;

    assign hmc_pulse = (hmc != 4'd0) & hblank & (hcount[1:0] == 2'b11);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hmc <= 4'd0;
        end else if ((line_start & sec) | (hmove & hblank)) begin
            hmc <= 4'd15;
        end else if (hmc_pulse) begin
            hmc <= hmc - 4'd1;
        end
    end
`else
    assign hmc_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_tia_htiming_param.sv
// Scoreboard bench for tia_htiming_param: a line-position model predicts every output each cycle.
module tb_tia_htiming_param;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wsyn = 0, hmove = 0, rsync = 0, vsyn = 0, vblk = 0, d1 = 0;
    logic [W-1:0] hcount;
    logic line_start, hblank, sec, vs, vb, vb_bar, blank, syn, cb, rdy, motck, hmc_pulse;

    tia_htiming_param dut (
        .clk(clk), .reset(reset), .wsyn(wsyn), .hmove(hmove), .rsync(rsync),
        .vsyn(vsyn), .vblk(vblk), .d1(d1), .hcount(hcount), .line_start(line_start),
        .hblank(hblank), .sec(sec), .vs(vs), .vb(vb), .vb_bar(vb_bar), .blank(blank),
        .syn(syn), .cb(cb), .rdy(rdy), .motck(motck), .hmc_pulse(hmc_pulse)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hc;
        logic [11:0]  fl;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;

    // Model state: position in line, HMOVE flag and where in the line it appeared.
    int pos, sec_from;
    bit m_sec, m_stall, m_vs, m_vb;

    function automatic exp_t expect_now();
        exp_t e;
        bit hb, hsw, cbw;
        hb  = (pos < 68) || (m_sec && sec_from <= 68 && pos < 76);
        hsw = (pos >= 20) && (pos < 36);
        cbw = (pos >= 40) && (pos < 56);
        e.hc = W'(pos);
        e.fl = {pos == 0, hb, m_sec, m_vs, m_vb, !m_vb, hb | m_vb,
                !(m_vs ^ hsw), !m_vs && cbw, !m_stall, !hb, 1'b0};
        return e;
    endfunction

    task automatic model_reset();
        pos = 0; sec_from = 0; m_sec = 0; m_stall = 0; m_vs = 0; m_vb = 0;
    endtask

    task automatic cyc(input bit w, input bit h, input bit r, input bit vsy, input bit vbl, input bit d);
        bit wr;
        int np;
        wsyn = w; hmove = h; rsync = r; vsyn = vsy; vblk = vbl; d1 = d;
        @(posedge clk);
        wr = r || (pos == 227);
        np = wr ? 0 : pos + 1;
        if (h) begin
            if (!m_sec || wr) sec_from = np;
            m_sec = 1;
        end else if (wr) m_sec = 0;
        if (w) m_stall = 1;
        else if (wr) m_stall = 0;
        if (vsy) m_vs = d;
        if (vbl) m_vb = d;
        pos = np;
        q.push_back(expect_now());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int p);
        int k;
        k = 0;
        while (pos != p && k < 600) begin
            cyc(0, 0, 0, 0, 0, 0);
            k++;
        end
        if (pos != p) begin
            checks++; errors++;
            $display("FAIL run_to position %0d required %0d", pos, p);
        end
    endtask

    task automatic mid_reset();
        #2 reset = 1'b1;
        model_reset();
        q.push_back(expect_now());
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks += 2;
            if (hcount !== e.hc) begin
                errors++;
                $display("FAIL hcount t=%0t got %0d exp %0d", $time, hcount, e.hc);
            end
            if ({line_start, hblank, sec, vs, vb, vb_bar, blank, syn, cb, rdy, motck, hmc_pulse} !== e.fl) begin
                errors++;
                $display("FAIL flags t=%0t hc=%0d got %b exp %b (ls hb sec vs vb vbb blank syn cb rdy motck hmc)",
                         $time, hcount,
                         {line_start, hblank, sec, vs, vb, vb_bar, blank, syn, cb, rdy, motck, hmc_pulse}, e.fl);
            end
        end
    end

    initial begin
        model_reset();
        q.push_back(expect_now());
        @(negedge clk);
        reset = 1'b0;

        idle(456);
        run_to(100); cyc(1, 0, 0, 0, 0, 0); run_to(10);
        run_to(227); cyc(1, 0, 0, 0, 0, 0); idle(300);
        run_to(10);  cyc(0, 1, 0, 0, 0, 0); idle(300);
        run_to(70);  cyc(0, 1, 0, 0, 0, 0); idle(230);
        run_to(227); cyc(0, 1, 0, 0, 0, 0); idle(230);
        run_to(67);  cyc(0, 1, 0, 0, 0, 0); idle(230);
        run_to(5);   cyc(0, 0, 0, 1, 0, 1); idle(230);
        cyc(0, 0, 0, 0, 1, 1); idle(230);
        cyc(0, 0, 0, 1, 1, 0); idle(10);
        run_to(120); cyc(1, 1, 0, 0, 0, 0); run_to(150); cyc(0, 0, 1, 0, 0, 0); idle(20);
        run_to(227); cyc(0, 0, 1, 0, 0, 0); idle(5);
        run_to(80);  cyc(1, 0, 0, 0, 0, 0); run_to(90); mid_reset(); idle(50);

        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1499) == 0) mid_reset();
        end

        @(negedge clk);
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
